// File: rtl/menu_nav_ctrl.sv
// menu_nav_ctrl: sequential front end for the 96x64 OLED game screens.
//   Debounces the four pushbuttons, runs the HOME / GAME / CONTROLS screen
//   state machine and produces the cursor-blink phase for the renderers.
//
// Ports:
//   clk         in   system clock (OLED driver domain)
//   rst_n       in   synchronous reset, active low
//   btn_up      in   raw pushbutton, asynchronous
//   btn_down    in   raw pushbutton, asynchronous
//   btn_centre  in   raw pushbutton, asynchronous
//   btn_back    in   raw pushbutton, asynchronous
//   frame_begin in   one-cycle pulse at the start of each OLED frame
//   screen_sel  out  0 = HOME, 1 = GAME, 2 = CONTROLS (this is the FSM state)
//   cursor      out  HOME item: 0 = "FLASHING CHAIR", 1 = "GAME CONTROL"
//   blink_on    out  1 = blinking icon / arrows visible
//   game_start  out  one-cycle pulse on entry to GAME
//
// Handshake: there is no valid/ready flow here. Each press is a one-cycle
// pulse that is consumed by the FSM in the cycle it is presented; it is never
// held, queued or back-pressured.
module menu_nav_ctrl #(
  parameter int DEBOUNCE_CYCLES = 62500,
  parameter int BLINK_FRAMES    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_centre,
  input  logic       btn_back,
  input  logic       frame_begin,
  output logic [1:0] screen_sel,
  output logic       cursor,
  output logic       blink_on,
  output logic       game_start
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  // Button bit order: [0]=up [1]=down [2]=centre [3]=back
  localparam int B_UP     = 0;
  localparam int B_DOWN   = 1;
  localparam int B_CENTRE = 2;
  localparam int B_BACK   = 3;

  typedef enum logic [1:0] {
    S_HOME     = 2'd0,
    S_GAME     = 2'd1,
    S_CONTROLS = 2'd2
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [3:0]    deb_d;
  logic [3:0]    press;
  logic [CW-1:0] deb_cnt [4];

  state_t        state;
  state_t        state_nxt;
  logic          cursor_nxt;
  logic          start_nxt;
  logic          view_changed;
  logic [BW-1:0] blink_cnt;

  logic win_back, win_centre, win_up, win_down;

  assign raw = {btn_back, btn_centre, btn_down, btn_up};

  // Debounce: two-flop synchroniser, then a counter of consecutive cycles in
  // which the synchronised level disagrees with the accepted level. The press
  // pulse is registered, adding one edge-detect cycle of latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == CNT_MAX) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Fixed priority back > centre > up > down; losing presses are dropped.
  assign win_back   = press[B_BACK];
  assign win_centre = press[B_CENTRE] & ~press[B_BACK];
  assign win_up     = press[B_UP] & ~press[B_BACK] & ~press[B_CENTRE];
  assign win_down   = press[B_DOWN] & ~press[B_BACK] & ~press[B_CENTRE] & ~press[B_UP];

  always_comb begin
    state_nxt  = state;
    cursor_nxt = cursor;
    start_nxt  = 1'b0;
    case (state)
      S_HOME: begin
        if (win_up || win_down) begin
          cursor_nxt = ~cursor;
        end else if (win_centre) begin
          if (cursor) begin
            state_nxt = S_CONTROLS;
          end else begin
            state_nxt = S_GAME;
            start_nxt = 1'b1;
          end
        end
      end
      S_GAME: begin
        if (win_back) begin
          state_nxt  = S_HOME;
          cursor_nxt = 1'b0;
        end
      end
      S_CONTROLS: begin
        if (win_back || win_centre) state_nxt = S_HOME;
      end
      default: state_nxt = S_HOME;
    endcase
  end

  assign view_changed = (state_nxt != state) || (cursor_nxt != cursor);

  // Screen FSM and blink phase. A view change restarts the blink phase lit,
  // swallowing any frame_begin that lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_HOME;
      cursor     <= 1'b0;
      game_start <= 1'b0;
      blink_on   <= 1'b1;
      blink_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      cursor     <= cursor_nxt;
      game_start <= start_nxt;
      if (view_changed) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (frame_begin) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign screen_sel = state;

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Testbench for menu_nav_ctrl with DEBOUNCE_CYCLES=4, BLINK_FRAMES=2.
// Directed scenario tasks plus a randomized run against a reference model.
// The model treats debounce as "raw level stable for DEB consecutive samples
// is accepted", with a fixed pipeline delay to the screen update, and
// implements the menu and blink rules directly.
module tb_menu_nav_ctrl;

  localparam int DEB = 4;
  localparam int BF  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_centre = 1'b0, btn_back = 1'b0;
  logic       frame_begin = 1'b0;
  logic [1:0] screen_sel;
  logic       cursor, blink_on, game_start;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int gs_cnt  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  menu_nav_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_centre(btn_centre), .btn_back(btn_back),
    .frame_begin(frame_begin),
    .screen_sel(screen_sel), .cursor(cursor), .blink_on(blink_on), .game_start(game_start)
  );

  // ---------------- reference model ----------------
  // mask bits: [0]=up [1]=down [2]=centre [3]=back
  int         m_sel, m_cur, m_blink, m_bcnt, m_gs;
  int         m_run  [4];
  logic       m_prev [4];
  logic       m_lvl  [4];
  logic [3:0] m_pend [8];

  task automatic model_clear();
    m_sel = 0; m_cur = 0; m_blink = 1; m_bcnt = 0; m_gs = 0;
    for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_prev[i] = 1'b0; m_lvl[i] = 1'b0; end
    for (int i = 0; i < 8; i++) m_pend[i] = 4'b0;
  endtask

  task automatic model_edge(input logic [3:0] b, input logic fb, input logic rst);
    int old_sel, old_cur;
    logic [3:0] act;
    if (!rst) begin
      model_clear();
    end else begin
      old_sel = m_sel; old_cur = m_cur;
      act = m_pend[edge_n % 8];
      m_pend[edge_n % 8] = 4'b0;
      m_gs = 0;
      if (act != 4'b0) begin
        if (m_sel == 0) begin
          if (act[3]) ;
          else if (act[2]) begin
            if (m_cur == 1) m_sel = 2; else begin m_sel = 1; m_gs = 1; end
          end else m_cur = 1 - m_cur;
        end else if (m_sel == 1) begin
          if (act[3]) begin m_sel = 0; m_cur = 0; end
        end else begin
          if (act[3] || act[2]) m_sel = 0;
        end
      end
      if (m_sel != old_sel || m_cur != old_cur) begin
        m_bcnt = 0; m_blink = 1;
      end else if (fb) begin
        if (m_bcnt == BF - 1) begin m_bcnt = 0; m_blink = 1 - m_blink; end
        else m_bcnt = m_bcnt + 1;
      end
      // A level stable for DEB samples is accepted; a new high level reaches
      // the screen state 4 edges after its DEB-th sample.
      for (int i = 0; i < 4; i++) begin
        if (b[i] == m_prev[i]) m_run[i] = m_run[i] + 1; else m_run[i] = 1;
        m_prev[i] = b[i];
        if (m_run[i] == DEB && b[i] != m_lvl[i]) begin
          m_lvl[i] = b[i];
          if (b[i]) m_pend[(edge_n + 4) % 8][i] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [3:0] b, input logic fb);
    {btn_back, btn_centre, btn_down, btn_up} = b;
    frame_begin = fb;
    @(posedge clk);
    edge_n++;
    model_edge(b, fb, rst_n);
    #1;
    if (game_start === 1'b1) gs_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'b0, 1'b0);
  endtask

  task automatic press(input logic [3:0] mask);
    repeat (DEB + 2) tick(mask, 1'b0);
    idle(DEB + 6);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick(4'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    do_reset(3);
    n_tests++; if (screen_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", screen_sel); end
    n_tests++; if (cursor !== 1'b0) begin n_fail++; $display("FAIL reset_cursor got %b exp 0", cursor); end
    n_tests++; if (blink_on !== 1'b1) begin n_fail++; $display("FAIL reset_blink got %b exp 1", blink_on); end
    n_tests++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL reset_gs got %b exp 0", game_start); end
    gs_cnt = 0;
    idle(100);
    n_tests++; if (screen_sel !== 2'd0 || cursor !== 1'b0 || blink_on !== 1'b1)
      begin n_fail++; $display("FAIL idle_outputs got sel=%0d cur=%b blink=%b exp 0/0/1", screen_sel, cursor, blink_on); end
    n_tests++; if (gs_cnt != 0) begin n_fail++; $display("FAIL idle_gs got %0d pulses exp 0", gs_cnt); end
  endtask

  task automatic test_debounce();
    int rise_edge, change_edge, toggles;
    logic prev_cur;
    repeat (3) tick(4'b0010, 1'b0);
    idle(5);
    n_tests++; if (cursor !== 1'b0) begin n_fail++; $display("FAIL glitch_cursor got %b exp 0", cursor); end
    rise_edge = edge_n + 1;   // first edge that samples the new level
    change_edge = -1; toggles = 0; prev_cur = cursor;
    repeat (20) begin
      tick(4'b0010, 1'b0);
      if (cursor !== prev_cur) begin
        toggles++;
        if (change_edge < 0) change_edge = edge_n;
      end
      prev_cur = cursor;
    end
    // 2 sync + DEB + edge detect + FSM, counted from the edge before the drive
    n_tests++; if (change_edge != rise_edge + DEB + 3)
      begin n_fail++; $display("FAIL deb_latency got edge %0d exp %0d", change_edge, rise_edge + DEB + 3); end
    n_tests++; if (toggles != 1) begin n_fail++; $display("FAIL deb_hold got %0d toggles exp 1", toggles); end
    repeat (20) begin
      tick(4'b0, 1'b0);
      if (cursor !== prev_cur) toggles++;
      prev_cur = cursor;
    end
    n_tests++; if (toggles != 1 || cursor !== 1'b1)
      begin n_fail++; $display("FAIL deb_release got toggles=%0d cur=%b exp 1/1", toggles, cursor); end
  endtask

  task automatic test_navigation();
    do_reset(1);
    press(4'b0010);
    press(4'b0100);
    n_tests++; if (screen_sel !== 2'd2) begin n_fail++; $display("FAIL nav_controls got %0d exp 2", screen_sel); end
    press(4'b1000);
    n_tests++; if (screen_sel !== 2'd0 || cursor !== 1'b1)
      begin n_fail++; $display("FAIL nav_back_ctl got sel=%0d cur=%b exp 0/1", screen_sel, cursor); end
    press(4'b0001);
    gs_cnt = 0;
    press(4'b0100);
    n_tests++; if (screen_sel !== 2'd1) begin n_fail++; $display("FAIL nav_game got %0d exp 1", screen_sel); end
    n_tests++; if (gs_cnt != 1) begin n_fail++; $display("FAIL nav_game_start got %0d cycles exp 1", gs_cnt); end
    press(4'b1000);
    n_tests++; if (screen_sel !== 2'd0 || cursor !== 1'b0)
      begin n_fail++; $display("FAIL nav_back_game got sel=%0d cur=%b exp 0/0", screen_sel, cursor); end
  endtask

  task automatic test_priority();
    do_reset(1);
    press(4'b0010);
    press(4'b0100);
    press(4'b1100);
    n_tests++; if (screen_sel !== 2'd0 || cursor !== 1'b1)
      begin n_fail++; $display("FAIL prio_back_centre got sel=%0d cur=%b exp 0/1", screen_sel, cursor); end
    press(4'b0001);
    press(4'b0101);
    n_tests++; if (screen_sel !== 2'd1 || cursor !== 1'b0)
      begin n_fail++; $display("FAIL prio_centre_up got sel=%0d cur=%b exp 1/0", screen_sel, cursor); end
  endtask

  task automatic test_blink();
    logic exp_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      tick(4'b0, 1'b1);
      n_tests++; if (blink_on !== exp_seq[k])
        begin n_fail++; $display("FAIL blink_seq[%0d] got %b exp %b", k, blink_on, exp_seq[k]); end
      tick(4'b0, 1'b0);
    end
    do_reset(1);
    repeat (3) begin tick(4'b0, 1'b1); tick(4'b0, 1'b0); end
    press(4'b0010);
    n_tests++; if (blink_on !== 1'b1 || cursor !== 1'b1)
      begin n_fail++; $display("FAIL blink_restart got blink=%b cur=%b exp 1/1", blink_on, cursor); end
    tick(4'b0, 1'b1);
    n_tests++; if (blink_on !== 1'b1) begin n_fail++; $display("FAIL blink_after_restart1 got %b exp 1", blink_on); end
    tick(4'b0, 1'b0);
    tick(4'b0, 1'b1);
    n_tests++; if (blink_on !== 1'b0) begin n_fail++; $display("FAIL blink_after_restart2 got %b exp 0", blink_on); end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    press(4'b0100);
    n_tests++; if (screen_sel !== 2'd1) begin n_fail++; $display("FAIL mid_enter_game got %0d exp 1", screen_sel); end
    repeat (3) tick(4'b1000, 1'b0);
    rst_n = 1'b0;
    tick(4'b1000, 1'b0);
    rst_n = 1'b1;
    n_tests++; if (screen_sel !== 2'd0 || cursor !== 1'b0 || blink_on !== 1'b1 || game_start !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset got sel=%0d cur=%b blink=%b gs=%b exp 0/0/1/0",
                               screen_sel, cursor, blink_on, game_start); end
    gs_cnt = 0;
    idle(30);
    n_tests++; if (screen_sel !== 2'd0 || cursor !== 1'b0 || gs_cnt != 0)
      begin n_fail++; $display("FAIL mid_no_late_action got sel=%0d cur=%b gs=%0d exp 0/0/0", screen_sel, cursor, gs_cnt); end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    logic       fb, last_fb;
    int         len;
    do_reset(2);
    last_fb = 1'b0;
    for (int it = 0; it < 40; it++) begin
      for (int ph = 0; ph < 2; ph++) begin
        mask = (ph == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
        len  = $urandom_range(1, DEB + 5);
        repeat (len) begin
          fb = !last_fb && ($urandom_range(0, 2) == 0);
          last_fb = fb;
          tick(mask, fb);
          n_tests++; if (screen_sel !== 2'(m_sel))
            begin n_fail++; $display("FAIL rnd_sel edge %0d got %0d exp %0d", edge_n, screen_sel, m_sel); end
          n_tests++; if (cursor !== 1'(m_cur))
            begin n_fail++; $display("FAIL rnd_cursor edge %0d got %b exp %0d", edge_n, cursor, m_cur); end
          n_tests++; if (blink_on !== 1'(m_blink))
            begin n_fail++; $display("FAIL rnd_blink edge %0d got %b exp %0d", edge_n, blink_on, m_blink); end
          n_tests++; if (game_start !== 1'(m_gs))
            begin n_fail++; $display("FAIL rnd_gs edge %0d got %b exp %0d", edge_n, game_start, m_gs); end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_clear();
    test_reset();
    test_debounce();
    test_navigation();
    test_priority();
    test_blink();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_nav_ctrl.md
Name: menu_nav_ctrl

Overview:
- Sequential front end for the 96x64 OLED game screens: debounces pushbuttons, runs the screen/menu state machine, and generates the cursor-blink phase.
- Drives screen selection and cursor/blink inputs of the combinational screen renderers.
- Renderers map (x,y) to oled_data; this block decides which renderer is muxed to the OLED driver and whether the blinking icon is lit.

Parameters:
- DEBOUNCE_CYCLES, 62500, consecutive stable synchronised cycles required to accept a button level change (10 ms at 6.25 MHz).
- BLINK_FRAMES, 15, frame_begin pulses per blink half-period.

Ports:
- clk  in  1  system clock; the OLED driver clock domain.
- rst_n  in  1  synchronous reset, active low.
- btn_up  in  1  raw pushbutton, asynchronous.
- btn_down  in  1  raw pushbutton, asynchronous.
- btn_centre  in  1  raw pushbutton, asynchronous.
- btn_back  in  1  raw pushbutton, asynchronous.
- frame_begin  in  1  one-cycle pulse from the OLED driver at the start of each frame.
- screen_sel  out  2  0 = HOME, 1 = GAME, 2 = CONTROLS; 3 is never driven.
- cursor  out  1  HOME menu item: 0 = "FLASHING CHAIR", 1 = "GAME CONTROL".
- blink_on  out  1  1 = blinking icon and arrows visible.
- game_start  out  1  one-cycle pulse on entry to GAME.

Behaviour:
- Clock/reset:
  - One clock; reset is synchronous and active-low.
  - While rst_n=0 at a clk edge: screen_sel=0, cursor=0, blink_on=1, game_start=0.
  - Debounced levels clear to 0, debounce counters to 0, blink counter to 0.
  - Asserting reset mid-operation (any state, mid-debounce) returns to these values on the next edge.
- Debounce (per button, identical instances):
  - Two-flop synchroniser.
  - Counter increments while the synchronised level differs from the debounced level; clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the debounced level takes the synchronised value and the counter clears.
  - press_x = 1-cycle pulse on a 0->1 transition of the debounced level. Releases generate nothing.
  - Holding a button yields exactly one press.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press arbitration:
  - Several presses in the same cycle: priority back > centre > up > down.
  - Only the winner acts; losers are discarded, not queued.
- FSM (registered outputs, state change one cycle after the press pulse):
  - HOME:
    - up/down toggle cursor (2 items, wrap both ways).
    - centre with cursor=0 -> GAME, game_start=1 for that one cycle.
    - centre with cursor=1 -> CONTROLS.
    - back ignored.
  - GAME:
    - back -> HOME, cursor forced to 0.
    - up/down/centre ignored by this block.
  - CONTROLS:
    - back or centre -> HOME, cursor stays 1.
    - up/down ignored.
  - Unreachable encoding 3 -> HOME on next edge.
- Blink:
  - Counter width ceil(log2(BLINK_FRAMES)), counts frame_begin pulses.
  - On the pulse where count = BLINK_FRAMES-1: blink_on toggles, counter clears.
  - Any screen_sel change or cursor change: counter=0, blink_on=1 in the same edge the new state is registered.
  - A frame_begin coinciding with that change is absorbed by the restart, giving no toggle.
  - frame_begin held high counts once per cycle; the driver guarantees single-cycle pulses.
- Timing:
  - Raw button edge to screen_sel update = 2 sync + DEBOUNCE_CYCLES + 1 edge-detect + 1 FSM cycles.

Test Plan:
- Reset and idle (DEBOUNCE_CYCLES=4, BLINK_FRAMES=2): hold rst_n=0 for 3 cycles, release; no buttons for 100 cycles -> screen_sel=0, cursor=0, blink_on=1, game_start never 1.
- Debounce: btn_down high for 3 cycles, low, then high for 20 cycles -> cursor toggles exactly once, 8 cycles after the second rising edge; hold gives no repeat; release gives no action.
- Navigation: down, centre -> screen_sel=2; back -> screen_sel=0 with cursor=1; up, centre -> screen_sel=1 and game_start high exactly 1 cycle; back -> screen_sel=0, cursor=0.
- Priority: btn_back and btn_centre rise in the same cycle while in CONTROLS -> HOME once. Repeat in HOME with cursor=0, up+centre together -> GAME, cursor unchanged.
- Blink: 6 frame_begin pulses in HOME -> blink_on sequence 1,0,0,1,1,0 sampled after each pulse. A down press between pulses 3 and 4 -> blink_on forced 1, counting restarts.
- Reset mid-operation: in GAME, mid-debounce of btn_back, pulse rst_n=0 one cycle -> all outputs at reset values next edge; the in-flight press must not produce a later action unless the button is still held for DEBOUNCE_CYCLES.
